// File: rtl/mem_port_arbiter_if.sv
// Handshake and bus signals between the two cache miss paths, the arbiter and memory.
// The arbiter uses the master modport; surrounding logic uses the slave modport.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ic_req_r;
    logic [AW-1:0] ic_addr;
    logic [DW-1:0] ic_rdata;
    logic          ic_ready;
    logic          dc_req_r;
    logic          dc_req_w;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic [DW-1:0] dc_rdata;
    logic          dc_ready;
    logic          mem_r;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          grant_d;

    modport master (
        input  ic_req_r, ic_addr, dc_req_r, dc_req_w, dc_addr, dc_wdata, mem_rdata, mem_ready,
        output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_r, mem_w, mem_addr, mem_wdata, grant_d
    );

    modport slave (
        output ic_req_r, ic_addr, dc_req_r, dc_req_w, dc_addr, dc_wdata, mem_rdata, mem_ready,
        input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_r, mem_w, mem_addr, mem_wdata, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache and D-cache miss paths.
// ARB_RR_EN selects round-robin arbitration; undefined gives fixed D-over-I priority.
//
// state | meaning
// IDLE  | no owner, strobes low, arbitrate pending requests
// OWN_I | I-cache owns the port, read in flight
// OWN_D | D-cache owns the port, read or write-back in flight
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ic_req, dc_req, win_d;
    logic          mem_r_c, mem_w_c, ic_ready_c, dc_ready_c, grant_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;

    assign ic_req = bus.ic_req_r;
    assign dc_req = bus.dc_req_r | bus.dc_req_w;

`ifdef ARB_RR_EN
    // 1: the D-cache wins the next tie; flips only on completed transfers
    logic rr_ptr_d;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr_d <= 1'b1;
        else if (ic_ready_c | dc_ready_c)
            rr_ptr_d <= ic_ready_c;
    end

    assign win_d = dc_req & (rr_ptr_d | ~ic_req);
`else
    assign win_d = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_r_c    = 1'b0;
        mem_w_c    = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        ic_ready_c = 1'b0;
        dc_ready_c = 1'b0;
        grant_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dc_req | ic_req)
                    state_d = win_d ? OWN_D : OWN_I;
            end
            OWN_I: begin
                mem_r_c = bus.ic_req_r;
                addr_c  = bus.ic_addr;
                if (!ic_req) begin
                    state_d = IDLE;
                end else if (bus.mem_ready) begin
                    ic_ready_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            OWN_D: begin
                grant_c = 1'b1;
                addr_c  = bus.dc_addr;
                wdata_c = bus.dc_wdata;
                // write wins when both are raised
                mem_w_c = bus.dc_req_w;
                mem_r_c = bus.dc_req_r & ~bus.dc_req_w;
                if (!dc_req) begin
                    state_d = IDLE;
                end else if (bus.mem_ready) begin
                    dc_ready_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_r     = mem_r_c;
    assign bus.mem_w     = mem_w_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.ic_ready  = ic_ready_c;
    assign bus.dc_ready  = dc_ready_c;
    assign bus.grant_d   = grant_c;
    assign bus.ic_rdata  = bus.mem_rdata;
    assign bus.dc_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected transfers plus a
// simple memory model with programmable ready latency.
module tb_mem_port_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    typedef struct packed {
        logic        is_d;
        logic        is_i;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } xact_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus();
    mem_port_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks   = 0;
    int          failures = 0;
    xact_t       sb[$];
    logic        ptr_model = 1'b1;
    logic        mdl_ready = 1'b0;
    logic        ext_ready = 1'b0;
    logic [31:0] mdl_rdata = 32'h0;
    logic [31:0] rval = 32'h0;
    int          mem_lat = 3;
    int          mcnt = 0;

    assign bus.mem_ready = mdl_ready | ext_ready;
    assign bus.mem_rdata = mdl_rdata;

    // memory model: ready asserted mem_lat cycles after the strobe is first seen
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if ((bus.mem_r || bus.mem_w) && !mdl_ready) begin
                if (mcnt >= mem_lat) begin
                    mdl_ready = 1'b1;
                    mdl_rdata = rval;
                    mcnt      = 0;
                end else begin
                    mcnt++;
                end
            end else begin
                mdl_ready = 1'b0;
                mcnt      = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic xact_t mk(input logic d, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd);
        xact_t x;
        x.is_d = d; x.is_i = ~d; x.wr = w; x.addr = a; x.wdata = wd; x.rdata = rd;
        return x;
    endfunction

    // waits for a ready pulse, captures the port, pops the matching expectation
    task automatic wait_ready(input int budget, output logic got, output xact_t obs,
                              output xact_t exp, output int n);
        got = 1'b0; obs = '0; exp = '0; n = 0;
        while (n < budget && !got) begin
            @(negedge clk);
            n++;
            if (bus.ic_ready || bus.dc_ready) begin
                got       = 1'b1;
                obs.is_d  = bus.dc_ready;
                obs.is_i  = bus.ic_ready;
                obs.wr    = bus.mem_w;
                obs.addr  = bus.mem_addr;
                obs.wdata = bus.mem_wdata;
                obs.rdata = bus.dc_ready ? bus.dc_rdata : bus.ic_rdata;
                if (sb.size() > 0) exp = sb.pop_front();
                ptr_model = bus.ic_ready;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ic_req_r = 0; bus.ic_addr = 0; bus.dc_req_r = 0; bus.dc_req_w = 0;
        bus.dc_addr = 0; bus.dc_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.mem_w, bus.ic_ready, bus.dc_ready, bus.grant_d} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got r/w/ir/dr/gd=%b want 00000",
                     {bus.mem_r, bus.mem_w, bus.ic_ready, bus.dc_ready, bus.grant_d});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        step();
        bus.dc_req_w = 1; bus.dc_addr = 32'h0000_0040; bus.dc_wdata = 32'h1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_w, bus.grant_d} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold: got mem_w=%b grant_d=%b want 0 0", bus.mem_w, bus.grant_d);
        end
        step();
        bus.dc_req_w = 0; bus.dc_addr = 0; bus.dc_wdata = 0;
        rst = 1'b0;
        ptr_model = 1'b1;
    endtask

    task automatic test_ic_only();
        logic got; xact_t obs, exp; int n;
        mem_lat = 3; rval = 32'hDEAD_BEEF;
        step();
        bus.ic_req_r = 1; bus.ic_addr = 32'h0000_1000;
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF));
        @(negedge clk);
        checks++;
        if (bus.mem_r !== 1'b0) begin
            failures++;
            $display("FAIL ic_idle_latency: got mem_r=%b want 0", bus.mem_r);
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.mem_w, bus.grant_d, bus.mem_addr} !== {3'b100, 32'h0000_1000}) begin
            failures++;
            $display("FAIL ic_strobe: got r=%b w=%b gd=%b addr=%h want 1 0 0 00001000",
                     bus.mem_r, bus.mem_w, bus.grant_d, bus.mem_addr);
        end
        wait_ready(20, got, obs, exp, n);
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL ic_xact: got %h want %h (seen=%b)", obs, exp, got);
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL ic_mem_latency: got %0d cycles want 3", n);
        end
        step();
        bus.ic_req_r = 0;
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.ic_ready, bus.dc_ready} !== 3'b000) begin
            failures++;
            $display("FAIL ic_idle_after: got r/ir/dr=%b want 000",
                     {bus.mem_r, bus.ic_ready, bus.dc_ready});
        end
    endtask

    task automatic test_simultaneous();
        logic got; xact_t obs, exp; int n;
        logic first_d;
        logic [31:0] a_first, a_second;
        mem_lat = 2; rval = 32'hCAFE_0001;
        first_d  = RR_ON ? ptr_model : 1'b1;
        a_first  = first_d ? 32'h0000_5000 : 32'h0000_4000;
        a_second = first_d ? 32'h0000_4000 : 32'h0000_5000;
        step();
        bus.ic_req_r = 1; bus.ic_addr = 32'h0000_4000;
        bus.dc_req_r = 1; bus.dc_addr = 32'h0000_5000; bus.dc_wdata = 0;
        sb.push_back(mk(first_d, 1'b0, a_first, 32'h0, rval));
        sb.push_back(mk(~first_d, 1'b0, a_second, 32'h0, rval));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.grant_d, bus.mem_addr} !== {first_d, a_first}) begin
            failures++;
            $display("FAIL sim_first_grant: got gd=%b addr=%h want gd=%b addr=%h",
                     bus.grant_d, bus.mem_addr, first_d, a_first);
        end
        wait_ready(20, got, obs, exp, n);
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL sim_first: got %h want %h (seen=%b)", obs, exp, got);
        end
        step();
        if (first_d) bus.dc_req_r = 0; else bus.ic_req_r = 0;
        @(negedge clk);
        checks++;
        if ({bus.grant_d, bus.mem_r, bus.mem_w} !== 3'b000) begin
            failures++;
            $display("FAIL sim_dead_cycle: got gd/r/w=%b want 000",
                     {bus.grant_d, bus.mem_r, bus.mem_w});
        end
        @(negedge clk);
        checks++;
        if ({bus.grant_d, bus.mem_r, bus.mem_addr} !== {~first_d, 1'b1, a_second}) begin
            failures++;
            $display("FAIL sim_second_grant: got gd=%b r=%b addr=%h want gd=%b r=1 addr=%h",
                     bus.grant_d, bus.mem_r, bus.mem_addr, ~first_d, a_second);
        end
        wait_ready(20, got, obs, exp, n);
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL sim_second: got %h want %h (seen=%b)", obs, exp, got);
        end
        step();
        bus.ic_req_r = 0; bus.dc_req_r = 0;
        @(negedge clk);
    endtask

    task automatic test_dirty_miss();
        logic got; xact_t obs, exp; int n;
        int dc_pulses = 0;
        mem_lat = 2; rval = 32'h0BAD_0BAD;
        step();
        bus.dc_req_w = 1; bus.dc_addr = 32'h0000_2000; bus.dc_wdata = 32'h1234_5678;
        sb.push_back(mk(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, rval));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_w, bus.mem_r, bus.grant_d, bus.mem_addr, bus.mem_wdata} !==
            {3'b101, 32'h0000_2000, 32'h1234_5678}) begin
            failures++;
            $display("FAIL wb_strobe: got w=%b r=%b gd=%b addr=%h wdata=%h",
                     bus.mem_w, bus.mem_r, bus.grant_d, bus.mem_addr, bus.mem_wdata);
        end
        wait_ready(20, got, obs, exp, n);
        if (got && obs.is_d) dc_pulses++;
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL wb_xact: got %h want %h (seen=%b)", obs, exp, got);
        end
        step();
        bus.dc_req_w = 0; bus.dc_req_r = 1; bus.dc_addr = 32'h0000_3000; bus.dc_wdata = 0;
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 32'h0, rval));
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.mem_w, bus.dc_ready} !== 3'b000) begin
            failures++;
            $display("FAIL dm_dead_cycle: got r/w/dr=%b want 000",
                     {bus.mem_r, bus.mem_w, bus.dc_ready});
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.mem_w, bus.mem_addr} !== {2'b10, 32'h0000_3000}) begin
            failures++;
            $display("FAIL fetch_strobe: got r=%b w=%b addr=%h want 1 0 00003000",
                     bus.mem_r, bus.mem_w, bus.mem_addr);
        end
        wait_ready(20, got, obs, exp, n);
        if (got && obs.is_d) dc_pulses++;
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL fetch_xact: got %h want %h (seen=%b)", obs, exp, got);
        end
        checks++;
        if (dc_pulses !== 2) begin
            failures++;
            $display("FAIL dm_ready_count: got %0d want 2", dc_pulses);
        end
        step();
        bus.dc_req_r = 0;
    endtask

    task automatic test_rw_both();
        logic got; xact_t obs, exp; int n;
        mem_lat = 1; rval = 32'h7777_0000;
        step();
        bus.dc_req_r = 1; bus.dc_req_w = 1; bus.dc_addr = 32'h0000_2100; bus.dc_wdata = 32'h55;
        sb.push_back(mk(1'b1, 1'b1, 32'h0000_2100, 32'h55, rval));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_w, bus.mem_r} !== 2'b10) begin
            failures++;
            $display("FAIL rw_both_is_write: got w=%b r=%b want 1 0", bus.mem_w, bus.mem_r);
        end
        wait_ready(20, got, obs, exp, n);
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL rw_both_xact: got %h want %h (seen=%b)", obs, exp, got);
        end
        step();
        bus.dc_req_r = 0; bus.dc_req_w = 0; bus.dc_wdata = 0;
    endtask

    task automatic test_abort();
        logic got; xact_t obs, exp; int n;
        mem_lat = 8; rval = 32'h0000_ABCD;
        step();
        bus.ic_req_r = 1; bus.ic_addr = 32'h0000_6000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_r !== 1'b1) begin
            failures++;
            $display("FAIL abort_granted: got mem_r=%b want 1", bus.mem_r);
        end
        step();
        bus.ic_req_r = 0;
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.ic_ready} !== 2'b00) begin
            failures++;
            $display("FAIL abort_strobe_drop: got r=%b ir=%b want 0 0", bus.mem_r, bus.ic_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_r, bus.mem_w, bus.grant_d, bus.ic_ready, bus.dc_ready} !== 5'b0) begin
            failures++;
            $display("FAIL abort_idle: got r/w/gd/ir/dr=%b want 00000",
                     {bus.mem_r, bus.mem_w, bus.grant_d, bus.ic_ready, bus.dc_ready});
        end
        wait_ready(10, got, obs, exp, n);
        checks++;
        if (got) begin
            failures++;
            $display("FAIL abort_no_ready: got ready pulse %h want none", obs);
        end
        mem_lat = 3; rval = 32'h0000_5A5A;
        step();
        bus.dc_req_w = 1; bus.dc_addr = 32'h0000_7000; bus.dc_wdata = 32'hA5A5_A5A5;
        sb.push_back(mk(1'b1, 1'b1, 32'h0000_7000, 32'hA5A5_A5A5, rval));
        wait_ready(20, got, obs, exp, n);
        checks++;
        if (!got || obs !== exp) begin
            failures++;
            $display("FAIL abort_then_dc: got %h want %h (seen=%b)", obs, exp, got);
        end
        step();
        bus.dc_req_w = 0; bus.dc_wdata = 0;
    endtask

    task automatic test_idle_ready();
        step();
        ext_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ic_ready, bus.dc_ready, bus.mem_r, bus.mem_w} !== 4'b0) begin
            failures++;
            $display("FAIL idle_ready_ignored: got ir/dr/r/w=%b want 0000",
                     {bus.ic_ready, bus.dc_ready, bus.mem_r, bus.mem_w});
        end
        step();
        ext_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_lat = 8;
        step();
        bus.dc_req_w = 1; bus.dc_addr = 32'h0000_8000; bus.dc_wdata = 32'h1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_w, bus.grant_d} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_owned: got w=%b gd=%b want 1 1", bus.mem_w, bus.grant_d);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_w, bus.mem_r, bus.grant_d, bus.ic_ready, bus.dc_ready} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_idle: got w/r/gd/ir/dr=%b want 00000",
                     {bus.mem_w, bus.mem_r, bus.grant_d, bus.ic_ready, bus.dc_ready});
        end
        step();
        bus.dc_req_w = 0; bus.dc_wdata = 0;
        rst = 1'b0;
        ptr_model = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic got; xact_t obs, exp; int n;
        logic p;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_model = 1'b1;
        mem_lat = 1; rval = 32'h0B2B_0000;
        p = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(p, 1'b0, p ? 32'h0000_A000 : 32'h0000_9000, 32'h0, rval));
            if (RR_ON) p = ~p;
        end
        step();
        bus.ic_req_r = 1; bus.ic_addr = 32'h0000_9000;
        bus.dc_req_r = 1; bus.dc_addr = 32'h0000_A000;
        for (int k = 0; k < 4; k++) begin
            wait_ready(20, got, obs, exp, n);
            checks++;
            if (!got || obs !== exp) begin
                failures++;
                $display("FAIL b2b_xfer%0d: got %h want %h (seen=%b)", k, obs, exp, got);
            end
        end
        step();
        bus.ic_req_r = 0; bus.dc_req_r = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ic_only();
        test_simultaneous();
        test_dirty_miss();
        test_rw_both();
        test_abort();
        test_idle_ready();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
